// File: rtl/reciprocal_seq_if.sv
// reciprocal_seq_if: byte-wide operand and result streams with
// valid/ready handshakes.
interface reciprocal_seq_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/reciprocal_seq.sv
// reciprocal_seq: byte-serial sequencer around a combinational reciprocal unit.
// Define RECIP_STATUS_BYTE_EN to append a {7'b0, sat} status byte to the result.
module reciprocal_seq #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_abs,
    reciprocal_seq_if.slave   io,
    output logic [23:0]       o_recip_data,
    output logic              o_recip_abs,
    input  logic [23:0]       i_recip_data,
    input  logic              i_recip_sat,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        SEND
    } state_t;

`ifdef RECIP_STATUS_BYTE_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [1:0]  idx;
    logic [3:0]  cnt;
    logic [23:0] result;
    logic [7:0]  out_byte;

`ifdef RECIP_STATUS_BYTE_EN
    logic sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (!i_clear && state == SETTLE && cnt == 4'd0) begin
            sat <= i_recip_sat;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = i_recip_sat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            idx          <= 2'd0;
            cnt          <= 4'd0;
            result       <= 24'd0;
            o_recip_data <= 24'd0;
            o_recip_abs  <= 1'b0;
        end else if (i_clear) begin
            state <= LOAD;
            idx   <= 2'd0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (io.in_valid) begin
                        unique case (idx)
                            2'd0: begin
                                o_recip_data[23:16] <= io.in_data;
                                o_recip_abs         <= i_abs;
                            end
                            2'd1: o_recip_data[15:8] <= io.in_data;
                            default: o_recip_data[7:0] <= io.in_data;
                        endcase
                        if (idx == 2'd2) begin
                            idx   <= 2'd0;
                            cnt   <= SETTLE_INIT;
                            state <= SETTLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        result <= i_recip_data;
                        state  <= SEND;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                SEND: begin
                    if (io.out_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= 2'd0;
                            state <= LOAD;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Output byte is a pure decode of result/idx, so it stays stable while stalled.
    always_comb begin
        out_byte = result[7:0];
        unique case (1'b1)
            (idx == 2'd0): out_byte = result[23:16];
            (idx == 2'd1): out_byte = result[15:8];
`ifdef RECIP_STATUS_BYTE_EN
            (idx == 2'd3): out_byte = {7'b0, sat};
`endif
            default: out_byte = result[7:0];
        endcase
    end

    assign io.out_data  = out_byte;
    assign io.in_ready  = (state == LOAD);
    assign io.out_valid = (state == SEND);
    assign o_busy       = (state != LOAD) || (idx != 2'd0);

endmodule

// File: tb/tb_reciprocal_seq.sv
// tb_reciprocal_seq: scoreboard bench for reciprocal_seq with an
// inverting reciprocal stub (data ^ FFFFFF, sat = abs).
module tb_reciprocal_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_abs = 1'b0;
    logic [23:0] o_recip_data;
    logic        o_recip_abs;
    logic [23:0] i_recip_data;
    logic        i_recip_sat;
    logic        o_busy;

    reciprocal_seq_if io ();

    reciprocal_seq #(.SETTLE_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (i_clear),
        .i_abs        (i_abs),
        .io           (io.slave),
        .o_recip_data (o_recip_data),
        .o_recip_abs  (o_recip_abs),
        .i_recip_data (i_recip_data),
        .i_recip_sat  (i_recip_sat),
        .o_busy       (o_busy)
    );

    assign i_recip_data = o_recip_data ^ 24'hFFFFFF;
    assign i_recip_sat  = o_recip_abs;

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    bit stall = 1'b0;
    int scnt = 0;
    bit prev_stall = 1'b0;
    logic [7:0] held = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // consumer ready: always high, or low 5 valid cycles per byte
    initial begin
        io.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall) begin
                io.out_ready = 1'b1;
            end else if (io.out_ready) begin
                io.out_ready = 1'b0;
                scnt = 0;
            end else if (io.out_valid) begin
                scnt++;
                io.out_ready = (scnt >= 5);
            end
        end
    end

    // output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n || !io.out_valid) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {24'b0, io.out_data}, {24'b0, held});
            if (io.out_ready && !i_clear) begin
                if (exp_q.size() == 0) begin
                    chk("out_q", exp_q.size(), 1);
                end else begin
                    chk("out_byte", {24'b0, io.out_data},
                        {24'b0, exp_q.pop_front()});
                end
            end
            prev_stall = !io.out_ready && !i_clear;
            held = io.out_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic a);
        int n = 0;
        bit ok;
        io.in_data  = b;
        io.in_valid = 1'b1;
        i_abs       = a;
        do begin
            @(negedge clk);
            ok = io.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) chk("in_tmo", 0, 1);
        io.in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [23:0] op, input logic a);
        exp_q.push_back(~op[23:16]);
        exp_q.push_back(~op[15:8]);
        exp_q.push_back(~op[7:0]);
`ifdef RECIP_STATUS_BYTE_EN
        exp_q.push_back({7'b0, a});
`endif
        send_byte(op[23:16], a);
        send_byte(op[15:8], a);
        send_byte(op[7:0], a);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        io.in_data  = 8'h00;
        io.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", io.in_ready, 1);
        chk("rst_vld", io.out_valid, 0);
        chk("rst_dat", io.out_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_recip", o_recip_data, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_rdy", io.in_ready, 1);
        chk("idle_busy", o_busy, 0);

        // basic op, abs=1
        send_op(24'h123456, 1'b1);
        chk("op_data", o_recip_data, 32'h123456);
        chk("op_abs", o_recip_abs, 1);
        chk("lat0", io.out_valid, 0);
        chk("rdy_set", io.in_ready, 0);
        @(posedge clk);
        #1;
        chk("lat1", io.out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat2", io.out_valid, 1);
        chk("busy", o_busy, 1);
        wait_drain();

        // stalled consumer, abs=0
        stall = 1'b1;
        send_op(24'h123456, 1'b0);
        wait_drain();
        stall = 1'b0;

        // input bytes offered while busy are ignored
        send_op(24'h00FF00, 1'b1);
        io.in_data  = 8'hFF;
        io.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rdy_lo", io.in_ready, 0);
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        chk("keep_op", o_recip_data, 32'h00FF00);
        wait_drain();
        send_op(24'h010203, 1'b0);
        chk("next_op", o_recip_data, 32'h010203);
        wait_drain();

        // clear after partial operand
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        chk("part_busy", o_busy, 1);
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        chk("clr_busy", o_busy, 0);
        chk("clr_rdy", io.in_ready, 1);
        send_op(24'hAABBCC, 1'b0);
        chk("clr_op", o_recip_data, 32'hAABBCC);
        wait_drain();

        // clear coincident with an output handshake
        send_op(24'h0FF03C, 1'b1);
        n = 0;
        while (!io.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cv_seen", io.out_valid, 1);
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        exp_q.delete();
        chk("cv_vld", io.out_valid, 0);
        chk("cv_rdy", io.in_ready, 1);
        chk("cv_busy", o_busy, 0);

        // async reset during SEND
        stall = 1'b1;
        send_op(24'h765432, 1'b0);
        n = 0;
        while (!io.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rs_seen", io.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rs_vld", io.out_valid, 0);
        chk("rs_rdy", io.in_ready, 1);
        chk("rs_dat", io.out_data, 0);
        chk("rs_recip", o_recip_data, 0);
        chk("rs_busy", o_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("rs_quiet", io.out_valid, 0);
        end
        chk("rs_rdy2", io.in_ready, 1);

        // normal op after reset
        @(posedge clk);
        #1;
        send_op(24'hFEDCBA, 1'b1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reciprocal_seq.md
# reciprocal_seq

Byte-serial sequencer that owns the shared combinational reciprocal datapath. It assembles a 24-bit operand from an 8-bit valid/ready input stream and presents it, plus the abs-mode flag, to the reciprocal unit. It waits a fixed number of settle cycles for the long combinational path, captures the 24-bit result and saturation flag, and streams them back out byte-serially. It sits between the tile's 8-bit pins and the reciprocal instance, so the datapath can be driven from narrow I/O without timing through it combinationally.

## Interface
- SETTLE_CYCLES, 2: cycles between operand complete and result capture; legal 1..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_clear  in  1  synchronous abort; returns to LOAD, discarding partial operand/result.
- i_abs  in  1  abs-mode request, sampled on acceptance of operand byte 0.
- i_in_data  in  8  operand byte, MSB-first.
- i_in_valid  in  1  operand byte valid.
- o_in_ready  out  1  sequencer accepts a byte this cycle.
- o_out_data  out  8  result/status byte, MSB-first.
- o_out_valid  out  1  o_out_data valid.
- i_out_ready  in  1  consumer accepts o_out_data this cycle.
- o_recip_data  out  24  operand to reciprocal unit.
- o_recip_abs  out  1  abs-mode to reciprocal unit.
- i_recip_data  in  24  reciprocal result.
- i_recip_sat  in  1  reciprocal saturation flag.
- o_busy  out  1  high in any state other than LOAD with byte count 0.

## Operation
- States: LOAD, SETTLE, SEND. Byte counter idx (2 bits), settle counter (4 bits).
- LOAD: o_in_ready=1. Handshake (valid&ready) writes i_in_data into o_recip_data byte [23:16], [15:8], [7:0] for idx 0,1,2. The idx 0 handshake also latches i_abs into o_recip_abs. After the idx 2 handshake: idx←0, settle counter←SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: o_in_ready=0, o_recip_data/o_recip_abs held. Counter decrements each cycle. In the cycle the counter reads 0: capture i_recip_data into the result register and i_recip_sat into the sat register, go to SEND.
- SEND: o_out_valid=1. o_out_data = result[23:16], [15:8], [7:0] for idx 0,1,2 (and the status byte, see Configuration). idx advances only on valid&ready. o_out_data is stable while valid and not ready. After the last byte's handshake: idx←0, go to LOAD.
- o_recip_data changes during LOAD. The reciprocal output is only meaningful after capture.
- i_clear (any state) has priority over any handshake in the same cycle. Next state is LOAD, idx=0, o_out_valid=0. o_recip_data, o_recip_abs and the result register keep their values.
- No arithmetic is performed. Widths are fixed at 24 bits.

## Timing
- Reset values: o_in_ready=1, o_out_valid=0, o_out_data=0, o_recip_data=0, o_recip_abs=0, o_busy=0, state LOAD, idx=0, result/sat=0.
- All outputs are registered or decoded from state registers only. There is no combinational path from i_out_ready or i_in_valid to any output.
- Let E0 be the edge accepting operand byte 2. Result capture happens on edge E0+SETTLE_CYCLES. o_out_valid rises after that same edge.
- Minimum transaction time is 3 + SETTLE_CYCLES + N_out cycles (N_out = 3 or 4). o_in_ready rises on the edge completing the last output handshake.
- Reset assertion mid-transaction returns all outputs to reset values immediately. No byte is emitted after reset release until a full operand is loaded.

## Configuration
- RECIP_STATUS_BYTE_EN defined: SEND emits a 4th byte {7'b0, sat} after result[7:0]; idx runs 0..3.
- Undefined: SEND emits 3 bytes only. The sat register and its capture logic are not built, and i_recip_sat is unused.

## Test plan
All scenarios use a bench stub with i_recip_data = o_recip_data ^ 24'hFFFFFF and i_recip_sat = o_recip_abs, with SETTLE_CYCLES=2.
- Reset, then idle: o_in_ready=1, o_out_valid=0, o_busy=0, o_recip_data=0.
- Send 12,34,56 with i_abs=1 and i_out_ready=1: o_recip_data=123456. o_out_valid rises 2 edges after the third byte. Output is ED,CB,A9, then 01 when the macro is defined.
- Same as the previous scenario with i_abs=0 and i_out_ready low for 5 cycles per byte: each byte is held stable while stalled. Output is ED,CB,A9 (plus 00 when the macro is defined).
- Drive i_in_valid high during SETTLE/SEND with a byte of FF: o_in_ready=0 and the next operand is unaffected.
- Assert i_clear after 2 operand bytes, then send AA,BB,CC: output is 55,44,33. Assert i_clear in the same cycle as an output handshake: o_out_valid=0 next cycle and o_in_ready=1.
- Pulse rst_n low during SEND: o_out_valid drops asynchronously, and after release o_in_ready=1 with no output emitted.
